// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder backed by a 64-bit wide data RAM.
// Performs RISC-V sized accesses with byte-lane stores and extended loads.
module data_mem_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   rdata_q;
  logic          err_q;
  logic [63:0]   mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic [2:0]    off;
  logic [1:0]    sz;
  logic          accept;
  logic          misalign;
  logic          out_of_range;
  logic          illegal;
  logic          acc_err;
  logic [7:0]    size_mask;
  logic [7:0]    byte_en;
  logic [63:0]   wdata_sh;
  logic [63:0]   rd_word;
  logic [63:0]   rd_sh;
  logic [63:0]   load_ext;

  assign idx         = req_addr_i[3 +: AW];
  assign off         = req_addr_i[2:0];
  assign sz          = req_funct3_i[1:0];
  assign req_ready_o = rst_n_i && (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    misalign  = 1'b0;
    size_mask = 8'h01;
    case (sz)
      2'd0: begin misalign = 1'b0;      size_mask = 8'h01; end
      2'd1: begin misalign = off[0];    size_mask = 8'h03; end
      2'd2: begin misalign = |off[1:0]; size_mask = 8'h0F; end
      default: begin misalign = |off;   size_mask = 8'hFF; end
    endcase
    out_of_range = |req_addr_i[63:3+AW];
    // Stores have no unsigned variants, so funct3[2] is illegal for them.
    illegal  = req_we_i ? req_funct3_i[2] : (req_funct3_i == 3'b111);
    acc_err  = misalign || out_of_range || illegal;
    byte_en  = size_mask << off;
    wdata_sh = req_wdata_i << {off, 3'b000};
  end

  assign rd_word = mem_q[idx];
  assign rd_sh   = rd_word >> {off, 3'b000};

  always_comb begin
    load_ext = 64'd0;
    case (req_funct3_i)
      3'b000:  load_ext = {{56{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  load_ext = {{48{rd_sh[15]}}, rd_sh[15:0]};
      3'b010:  load_ext = {{32{rd_sh[31]}}, rd_sh[31:0]};
      3'b011:  load_ext = rd_sh;
      3'b100:  load_ext = {56'd0, rd_sh[7:0]};
      3'b101:  load_ext = {48'd0, rd_sh[15:0]};
      3'b110:  load_ext = {32'd0, rd_sh[31:0]};
      default: load_ext = 64'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (accept && !acc_err && req_we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) begin
          mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || req_we_i) ? 64'd0 : load_ext;
            if (LATENCY == 1) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= (LATENCY > 1) ? CW'(LATENCY - 2) : '0;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q <= S_IDLE;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-vector bench for data_mem_responder with a queue-based scoreboard
// and an independent monitor checking latency, hold stability and responses.
module tb_data_mem_responder;

  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err)
  );

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp_e;
  int          total = 0;
  int          bad = 0;
  int          rsp_cnt = 0;
  int          exp_cnt = 0;
  logic        tracking = 1'b0;
  int          lat = 0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data;
  logic        prev_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      tracking  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (tracking) begin
        lat++;
        if (rsp_valid) begin
          check("latency", 64'(lat), 64'(LAT));
          tracking = 1'b0;
        end else if (lat > LAT) begin
          check("latency_timeout", 64'(lat), 64'(LAT));
          tracking = 1'b0;
        end else begin
          check("wait_req_ready", {63'd0, req_ready}, 64'd0);
        end
      end
      if (prev_hold) begin
        check("hold_valid", {63'd0, rsp_valid}, 64'd1);
        check("hold_data", rsp_rdata, prev_data);
        check("hold_err", {63'd0, rsp_err}, {63'd0, prev_err});
      end
      prev_hold = 1'b0;
      if (rsp_valid) begin
        check("resp_req_ready", {63'd0, req_ready}, 64'd0);
        if (!rsp_ready) begin
          prev_hold = 1'b1;
          prev_data = rsp_rdata;
          prev_err  = rsp_err;
        end else begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: actual data=%h err=%b required none", rsp_rdata, rsp_err);
          end else begin
            exp_e = exp_q.pop_front();
            check("rsp_err", {63'd0, rsp_err}, {63'd0, exp_e.err});
            check("rsp_data", rsp_rdata, exp_e.data);
            $display("rsp %0d: data=%h err=%b", rsp_cnt, rsp_rdata, rsp_err);
          end
          rsp_cnt++;
        end
      end
      if (req_valid && req_ready) begin
        tracking = 1'b1;
        lat = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic e_err, input logic [63:0] e_data,
                       input bit expect_rsp);
    int n;
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (expect_rsp) begin
      exp_q.push_back({e_err, e_data});
      exp_cnt++;
    end
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: actual ready=%b required 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    $display("req: we=%b f3=%b addr=%h wdata=%h", we, f3, addr, wd);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rsp_cnt != exp_cnt && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: actual count=%0d required %0d", rsp_cnt, exp_cnt);
      rsp_cnt = exp_cnt;
    end
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                     input logic [63:0] wd, input logic e_err, input logic [63:0] e_data);
    issue(we, f3, addr, wd, e_err, e_data, 1'b1);
    wait_done();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {63'd0, req_ready}, 64'd0);
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rdata", rsp_rdata, 64'd0);
    check("reset_err", {63'd0, rsp_err}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_req_ready", {63'd0, req_ready}, 64'd1);

    // Double store/load, then byte-granular traffic on the same word.
    txn(1'b1, 3'b011, 64'h10, 64'h0123456789ABCDEF, 1'b0, 64'd0);
    txn(1'b0, 3'b011, 64'h10, 64'd0, 1'b0, 64'h0123456789ABCDEF);
    txn(1'b0, 3'b000, 64'h17, 64'd0, 1'b0, 64'h0000000000000001);
    txn(1'b1, 3'b000, 64'h17, 64'h80, 1'b0, 64'd0);
    txn(1'b0, 3'b000, 64'h17, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFF80);
    txn(1'b0, 3'b100, 64'h17, 64'd0, 1'b0, 64'h0000000000000080);
    txn(1'b0, 3'b011, 64'h10, 64'd0, 1'b0, 64'h8023456789ABCDEF);

    // Misaligned store must not disturb RAM; word and half lanes.
    txn(1'b1, 3'b011, 64'h20, 64'd0, 1'b0, 64'd0);
    txn(1'b1, 3'b001, 64'h21, 64'hBEEF, 1'b1, 64'd0);
    txn(1'b0, 3'b011, 64'h20, 64'd0, 1'b0, 64'd0);
    txn(1'b1, 3'b010, 64'h24, 64'h111111119ABCDEF0, 1'b0, 64'd0);
    txn(1'b0, 3'b110, 64'h24, 64'd0, 1'b0, 64'h000000009ABCDEF0);
    txn(1'b0, 3'b010, 64'h24, 64'd0, 1'b0, 64'hFFFFFFFF9ABCDEF0);
    txn(1'b1, 3'b001, 64'h22, 64'h7FFF1234, 1'b0, 64'd0);
    txn(1'b1, 3'b001, 64'h26, 64'h8001, 1'b0, 64'd0);
    txn(1'b0, 3'b001, 64'h26, 64'd0, 1'b0, 64'hFFFFFFFFFFFF8001);
    txn(1'b0, 3'b101, 64'h26, 64'd0, 1'b0, 64'h0000000000008001);
    txn(1'b0, 3'b011, 64'h20, 64'd0, 1'b0, 64'h8001DEF012340000);

    // Error cases and the last valid word.
    txn(1'b0, 3'b011, 64'h1000, 64'd0, 1'b1, 64'd0);
    txn(1'b0, 3'b111, 64'h10, 64'd0, 1'b1, 64'd0);
    txn(1'b1, 3'b100, 64'h10, 64'hFF, 1'b1, 64'd0);
    txn(1'b0, 3'b011, 64'h14, 64'd0, 1'b1, 64'd0);
    txn(1'b0, 3'b010, 64'h12, 64'd0, 1'b1, 64'd0);
    txn(1'b0, 3'b011, 64'h8000000000000010, 64'd0, 1'b1, 64'd0);
    txn(1'b1, 3'b011, 64'hFF8, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 64'd0);
    txn(1'b0, 3'b011, 64'hFF8, 64'd0, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0);

    // Back-pressure: response held for 5 cycles.
    rsp_ready = 1'b0;
    issue(1'b0, 3'b011, 64'h10, 64'd0, 1'b0, 64'h8023456789ABCDEF, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_reached_resp", {63'd0, rsp_valid}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_done();
    check("ready_after_rsp", {63'd0, req_ready}, 64'd1);

    // Reset while in WAIT after a store: no response, store persists.
    issue(1'b1, 3'b011, 64'h30, 64'hCAFEF00D55AA33CC, 1'b0, 64'd0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("abort_rdata", rsp_rdata, 64'd0);
    check("abort_err", {63'd0, rsp_err}, 64'd0);
    check("abort_req_ready", {63'd0, req_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
    rst_n = 1'b1;
    txn(1'b0, 3'b011, 64'h30, 64'd0, 1'b0, 64'hCAFEF00D55AA33CC);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
